ias_seq_ctrl: RTL and testbench

//   Parametrised successor controller for the iterative add/sub (IAS) datapath.

---
 rtl/ias_pkg.sv | 20 ++
 rtl/ias_seq_ctrl_if.sv | 41 ++++
 rtl/ias_step_cnt.sv | 31 +++
 rtl/ias_seq_ctrl.sv | 110 +++++++++++
 tb/tb_ias_seq_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ias_pkg.sv
// Shared encodings for the iterative add/sub (IAS) sequencing controller.
// Configuration macro used by the files of this block: IAS_ABORT_EN.
package ias_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_CALC   = 2'd2,
        ST_FINISH = 2'd3
    } ias_state_t;

    localparam logic IAS_ADD = 1'b1;
    localparam logic IAS_SUB = 1'b0;

    // Step counter width; a single-step build still needs a 1-bit counter.
    function automatic int ias_cnt_w(input int n_steps);
        return ($clog2(n_steps) > 0) ? $clog2(n_steps) : 1;
    endfunction

endpackage

// File: rtl/ias_seq_ctrl_if.sv
// Op/result handshake plus datapath strobes between the master, the controller and the IAS datapath.
// IAS_ABORT_EN adds the abort request line.
interface ias_seq_ctrl_if
    import ias_pkg::*;
#(
    parameter int N_STEPS = 4,
    parameter int CNT_W   = ias_cnt_w(N_STEPS)
) ();

    logic               val_op;
    logic [N_STEPS-1:0] a_s;
    logic               op_ack;
    logic               op_rdy;
    logic               res_ack;
    logic               reg_en_1;
    logic               reg_en_2;
    logic               add_sub;
    logic [CNT_W-1:0]   step_idx;
    logic               busy;
    logic               sen;
`ifdef IAS_ABORT_EN
    logic               abort;
`endif

    modport master (
`ifdef IAS_ABORT_EN
        output abort,
`endif
        output val_op, a_s, res_ack, sen,
        input  op_ack, op_rdy, reg_en_1, reg_en_2, add_sub, step_idx, busy
    );

    modport slave (
`ifdef IAS_ABORT_EN
        input  abort,
`endif
        input  val_op, a_s, res_ack, sen,
        output op_ack, op_rdy, reg_en_1, reg_en_2, add_sub, step_idx, busy
    );

endinterface

// File: rtl/ias_step_cnt.sv
// CALC step counter: cleared on START, advances while enabled, saturates on the last step.
module ias_step_cnt
    import ias_pkg::*;
#(
    parameter int N_STEPS = 4,
    parameter int CNT_W   = ias_cnt_w(N_STEPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    assign o_last  = (r_count == CNT_W'(N_STEPS - 1));
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_last) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ias_seq_ctrl.sv
// IAS sequencing controller: IDLE -> START -> N_STEPS x CALC -> FINISH, frozen while sen=1.
// Optional cancel path built when IAS_ABORT_EN is defined.
module ias_seq_ctrl
    import ias_pkg::*;
#(
    parameter int N_STEPS = 4,
    parameter int CNT_W   = ias_cnt_w(N_STEPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    ias_seq_ctrl_if.slave    bus
);

    ias_state_t         r_state;
    ias_state_t         w_state_next;
    logic [N_STEPS-1:0] r_mask;
    logic [CNT_W-1:0]   w_count;
    logic               w_last;
    logic               w_clear;
    logic               w_enable;

    logic               w_op_ack;
    logic               w_op_rdy;
    logic               w_reg_en_1;
    logic               w_reg_en_2;
    logic               w_add_sub;
    logic [CNT_W-1:0]   w_step_idx;
    logic               w_busy;

    // Counter and mask only move when the scan chain is not holding the block.
    assign w_clear  = (r_state == ST_START) && !bus.sen;
    assign w_enable = (r_state == ST_CALC)  && !bus.sen;

    ias_step_cnt #(
        .N_STEPS (N_STEPS),
        .CNT_W   (CNT_W)
    ) u_step_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_count  (w_count),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_clear) begin
            r_mask <= bus.a_s;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_ack     = 1'b0;
        w_op_rdy     = 1'b0;
        w_reg_en_1   = 1'b0;
        w_reg_en_2   = 1'b0;
        w_add_sub    = IAS_ADD;
        w_step_idx   = '0;
        w_busy       = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (bus.val_op) w_state_next = ST_START;
            end
            ST_START: begin
                w_op_ack     = !bus.sen;
                w_reg_en_1   = !bus.sen;
                w_state_next = ST_CALC;
            end
            ST_CALC: begin
                w_reg_en_2 = !bus.sen;
                w_add_sub  = r_mask[w_count];
                w_step_idx = w_count;
                if (w_last) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                w_op_rdy = 1'b1;
                if (bus.res_ack) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

`ifdef IAS_ABORT_EN
        if (bus.abort && (r_state != ST_IDLE)) w_state_next = ST_IDLE;
`endif

        // Scan freeze overrides every transition, including abort.
        if (bus.sen) w_state_next = r_state;
    end

    assign bus.op_ack   = w_op_ack;
    assign bus.op_rdy   = w_op_rdy;
    assign bus.reg_en_1 = w_reg_en_1;
    assign bus.reg_en_2 = w_reg_en_2;
    assign bus.add_sub  = w_add_sub;
    assign bus.step_idx = w_step_idx;
    assign bus.busy     = w_busy;

endmodule

// File: tb/tb_ias_seq_ctrl.sv
// Bench for ias_seq_ctrl: directed scenarios plus randomized traffic against a position-based reference model.
module tb_ias_seq_ctrl;
    import ias_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position in the transaction (0 idle, 1 start, 2..N+1 calc steps, N+2 finish).
    int           m_pos  = 0;
    logic [N-1:0] m_mask = '0;

    ias_seq_ctrl_if #(.N_STEPS(N)) if0 ();
    ias_seq_ctrl_if #(.N_STEPS(1)) if1 ();

    ias_seq_ctrl #(.N_STEPS(N)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    ias_seq_ctrl #(.N_STEPS(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    function automatic logic [7:0] obs0();
        return {if0.op_ack, if0.op_rdy, if0.reg_en_1, if0.reg_en_2,
                if0.add_sub, if0.busy, if0.step_idx};
    endfunction

    function automatic logic [7:0] model_outs();
        logic       calc;
        int         k;
        logic [1:0] sidx;
        calc = (m_pos >= 2) && (m_pos <= N + 1);
        k    = calc ? m_pos - 2 : 0;
        sidx = 2'(k);
        return {(m_pos == 1) && !if0.sen, (m_pos == N + 2), (m_pos == 1) && !if0.sen,
                calc && !if0.sen, calc ? m_mask[k] : 1'b1, (m_pos != 0), sidx};
    endfunction

    task automatic tick();
        int           np;
        logic [N-1:0] nm;
        np = m_pos;
        nm = m_mask;
        if (!reset_n) begin
            np = 0;
            nm = '0;
        end else if (!if0.sen) begin
            if (m_pos == 0) begin
                if (if0.val_op) np = 1;
            end else if (m_pos == 1) begin
                nm = if0.a_s;
                np = 2;
            end else if (m_pos <= N + 1) begin
                np = m_pos + 1;
            end else if (if0.res_ack) begin
                np = 0;
            end
`ifdef IAS_ABORT_EN
            if (if0.abort && m_pos != 0) np = 0;
`endif
        end
        @(posedge clk);
        #1;
        m_pos  = np;
        m_mask = nm;
    endtask

    task automatic idle_inputs();
        if0.val_op = 1'b0; if0.a_s = '0; if0.res_ack = 1'b0; if0.sen = 1'b0;
        if1.val_op = 1'b0; if1.a_s = '0; if1.res_ack = 1'b0; if1.sen = 1'b0;
`ifdef IAS_ABORT_EN
        if0.abort = 1'b0;
        if1.abort = 1'b0;
`endif
    endtask

    // Bounded wait for op_rdy on dut0 followed by a one-cycle acknowledge.
    task automatic drain0();
        int cnt;
        cnt = 0;
        while (!if0.op_rdy && cnt < 30) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (!if0.op_rdy) begin
            n_fail++;
            $display("FAIL drain_timeout: op_rdy=%0b after %0d cycles, required 1", if0.op_rdy, cnt);
        end
        if0.res_ack = 1'b1;
        tick();
        if0.res_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs0() !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL reset_outs_n4: got %b, required %b", obs0(), 8'b0000_1000);
        end
        n_checks++;
        if ({if1.op_ack, if1.op_rdy, if1.reg_en_1, if1.reg_en_2, if1.add_sub, if1.busy, if1.step_idx} !== 7'b0000100) begin
            n_fail++;
            $display("FAIL reset_outs_n1: got %b, required %b",
                     {if1.op_ack, if1.op_rdy, if1.reg_en_1, if1.reg_en_2, if1.add_sub, if1.busy, if1.step_idx}, 7'b0000100);
        end
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        n_checks++;
        if (if0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b, required 0", if0.busy);
        end
    endtask

    task automatic test_basic();
        logic exp_as;
        if0.a_s = 4'b0101; if0.val_op = 1'b1; if0.res_ack = 1'b1;
        tick();
        n_checks++;
        if ({if0.op_ack, if0.reg_en_1, if0.busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL basic_ack: op_ack/reg_en_1/busy=%b, required 111", {if0.op_ack, if0.reg_en_1, if0.busy});
        end
        if0.val_op = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            exp_as = (k % 2 == 0);
            n_checks++;
            if ({if0.reg_en_2, if0.add_sub, if0.step_idx, if0.op_rdy} !== {1'b1, exp_as, 2'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL basic_step%0d: reg_en_2/add_sub/step_idx/op_rdy=%b, required %b", k,
                         {if0.reg_en_2, if0.add_sub, if0.step_idx, if0.op_rdy}, {1'b1, exp_as, 2'(k), 1'b0});
            end
        end
        tick();
        n_checks++;
        if ({if0.op_rdy, if0.busy, if0.reg_en_2} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_rdy_cycle6: op_rdy/busy/reg_en_2=%b, required 110", {if0.op_rdy, if0.busy, if0.reg_en_2});
        end
        tick();
        n_checks++;
        if ({if0.op_rdy, if0.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle_cycle7: op_rdy/busy=%b, required 00", {if0.op_rdy, if0.busy});
        end
        if0.res_ack = 1'b0;
    endtask

    task automatic test_hold();
        int cnt;
        if0.a_s = 4'($urandom); if0.val_op = 1'b1; if0.res_ack = 1'b0;
        tick();
        cnt = 0;
        while (!if0.op_rdy && cnt < 20) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != N + 1) begin
            n_fail++;
            $display("FAIL hold_latency: op_rdy after %0d cycles past op_ack, required %0d", cnt, N + 1);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({if0.op_rdy, if0.op_ack} !== 2'b10) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: op_rdy/op_ack=%b, required 10", i, {if0.op_rdy, if0.op_ack});
            end
            tick();
        end
        if0.res_ack = 1'b1;
        tick();
        if0.res_ack = 1'b0;
        n_checks++;
        if ({if0.op_ack, if0.busy, if0.op_rdy} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_after_ack: op_ack/busy/op_rdy=%b, required 000", {if0.op_ack, if0.busy, if0.op_rdy});
        end
        tick();
        n_checks++;
        if (if0.op_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_next_ack: op_ack=%b, required 1", if0.op_ack);
        end
        if0.val_op = 1'b0;
        drain0();
    endtask

    task automatic test_scan();
        logic [N-1:0] as;
        int cyc;
        as = 4'($urandom);
        if0.a_s = as; if0.val_op = 1'b1;
        tick();
        if0.val_op = 1'b0;
        tick(); tick(); tick();
        cyc = 4;
        if0.sen = 1'b1;
        #1;
        n_checks++;
        if ({if0.step_idx, if0.reg_en_2, if0.busy, if0.add_sub} !== {2'd2, 1'b0, 1'b1, as[2]}) begin
            n_fail++;
            $display("FAIL scan_enter: step_idx/reg_en_2/busy/add_sub=%b, required %b",
                     {if0.step_idx, if0.reg_en_2, if0.busy, if0.add_sub}, {2'd2, 1'b0, 1'b1, as[2]});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc++;
            if (i < 2) begin
                n_checks++;
                if ({if0.step_idx, if0.reg_en_2, if0.reg_en_1, if0.op_ack} !== {2'd2, 3'b000}) begin
                    n_fail++;
                    $display("FAIL scan_frozen%0d: step_idx/reg_en_2/reg_en_1/op_ack=%b, required 10000", i,
                             {if0.step_idx, if0.reg_en_2, if0.reg_en_1, if0.op_ack});
                end
            end
        end
        if0.sen = 1'b0;
        #1;
        n_checks++;
        if ({if0.step_idx, if0.reg_en_2, if0.add_sub} !== {2'd2, 1'b1, as[2]}) begin
            n_fail++;
            $display("FAIL scan_resume: step_idx/reg_en_2/add_sub=%b, required %b",
                     {if0.step_idx, if0.reg_en_2, if0.add_sub}, {2'd2, 1'b1, as[2]});
        end
        while (!if0.op_rdy && cyc < 30) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != N + 2 + 3) begin
            n_fail++;
            $display("FAIL scan_latency: op_rdy at cycle %0d, required %0d", cyc, N + 5);
        end
        if0.res_ack = 1'b1;
        tick();
        if0.res_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        int rdy_seen;
        if0.a_s = 4'($urandom); if0.val_op = 1'b1;
        tick();
        if0.val_op = 1'b0;
        tick(); tick();
        n_checks++;
        if (if0.step_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL arst_pre_step: step_idx=%0d, required 1", if0.step_idx);
        end
        #3 reset_n = 1'b0;
        m_pos  = 0;
        m_mask = '0;
        #1;
        n_checks++;
        if (obs0() !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b, required %b", obs0(), 8'b0000_1000);
        end
        tick(); tick();
        #3 reset_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if0.op_rdy !== 1'b0 || if0.busy !== 1'b0) rdy_seen++;
        end
        n_checks++;
        if (rdy_seen != 0) begin
            n_fail++;
            $display("FAIL arst_no_rdy: %0d cycles with op_rdy/busy set, required 0", rdy_seen);
        end
    endtask

    task automatic test_single_step();
        int cyc;
        for (int a = 0; a < 2; a++) begin
            if1.a_s = 1'(a); if1.val_op = 1'b1;
            tick();
            cyc = 1;
            n_checks++;
            if ({if1.op_ack, if1.reg_en_1} !== 2'b11) begin
                n_fail++;
                $display("FAIL n1_ack_a%0d: op_ack/reg_en_1=%b, required 11", a, {if1.op_ack, if1.reg_en_1});
            end
            if1.val_op = 1'b0;
            tick();
            cyc++;
            n_checks++;
            if ({if1.reg_en_2, if1.add_sub, if1.step_idx, if1.op_rdy} !== {1'b1, 1'(a), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL n1_calc_a%0d: reg_en_2/add_sub/step_idx/op_rdy=%b, required %b", a,
                         {if1.reg_en_2, if1.add_sub, if1.step_idx, if1.op_rdy}, {1'b1, 1'(a), 1'b0, 1'b0});
            end
            tick();
            cyc++;
            n_checks++;
            if (if1.op_rdy !== 1'b1 || cyc != 3) begin
                n_fail++;
                $display("FAIL n1_rdy_a%0d: op_rdy=%b at cycle %0d, required 1 at cycle 3", a, if1.op_rdy, cyc);
            end
            if1.res_ack = 1'b1;
            tick();
            if1.res_ack = 1'b0;
            n_checks++;
            if (if1.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL n1_idle_a%0d: busy=%b, required 0", a, if1.busy);
            end
        end
    endtask

`ifdef IAS_ABORT_EN
    task automatic test_abort();
        int cyc;
        if0.a_s = 4'($urandom); if0.val_op = 1'b1;
        tick();
        if0.val_op = 1'b0;
        tick(); tick();
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        n_checks++;
        if ({if0.busy, if0.op_rdy, if0.reg_en_2} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle: busy/op_rdy/reg_en_2=%b, required 000", {if0.busy, if0.op_rdy, if0.reg_en_2});
        end
        if0.a_s = 4'b1010; if0.val_op = 1'b1;
        tick();
        if0.val_op = 1'b0;
        n_checks++;
        if (if0.op_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next_ack: op_ack=%b, required 1", if0.op_ack);
        end
        cyc = 1;
        while (!if0.op_rdy && cyc < 30) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != N + 2) begin
            n_fail++;
            $display("FAIL abort_next_latency: op_rdy at cycle %0d, required %0d", cyc, N + 2);
        end
        if0.res_ack = 1'b1;
        tick();
        if0.res_ack = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        if0.val_op = 1'b1; if0.res_ack = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if0.a_s = 4'($urandom);
            tick();
            if (if0.op_ack === 1'b1) acks++;
            n_checks++;
            if (obs0() !== model_outs()) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %b, required %b", i, obs0(), model_outs());
            end
        end
        n_checks++;
        if (acks != 3) begin
            n_fail++;
            $display("FAIL b2b_ack_count: %0d op_ack pulses, required 3", acks);
        end
        if0.val_op = 1'b0; if0.res_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            tick();
            if0.val_op  = 1'($urandom_range(0, 1));
            if0.res_ack = 1'($urandom_range(0, 1));
            if0.sen     = ($urandom_range(0, 7) == 0);
            if0.a_s     = 4'($urandom);
`ifdef IAS_ABORT_EN
            if0.abort   = ($urandom_range(0, 15) == 0);
`endif
            #1;
            n_checks++;
            if (obs0() !== model_outs()) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got %b, required %b (model pos %0d)", i, obs0(), model_outs(), m_pos);
            end
        end
        idle_inputs();
        if0.res_ack = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        if0.res_ack = 1'b0;
        n_checks++;
        if (if0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: busy=%b, required 0", if0.busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_scan();
        test_async_reset();
        test_single_step();
`ifdef IAS_ABORT_EN
        test_abort();
`endif
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
